// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register hazard scoreboard for long-latency writes
module hazard_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int REG_W     = 5,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1,
  parameter int PERF_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_is_long,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd,
  input  logic                flush,
  output logic                stall,
  output logic                stall_raw,
  output logic                stall_waw,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [PERF_W-1:0]   stall_cycles,
  output logic                underflow_err
);

  // Table spans the full index space so any index is legal; unused entries are constant 0.
  localparam int TBL = 2 ** REG_W;

  logic [CNT_W-1:0] pend_cnt [TBL];
  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
  logic             rel_rs1, rel_rs2, issue, underflow_ev;

  assign cnt_rs1 = pend_cnt[id_rs1];
  assign cnt_rs2 = pend_cnt[id_rs2];
  assign cnt_rd  = pend_cnt[id_rd];
  assign cnt_wb  = pend_cnt[wb_rd];

  // A last outstanding write landing this cycle frees its readers when bypass is enabled.
  assign rel_rs1 = (WB_BYPASS != 0) && wb_valid && (wb_rd == id_rs1) && (cnt_rs1 == CNT_W'(1));
  assign rel_rs2 = (WB_BYPASS != 0) && wb_valid && (wb_rd == id_rs2) && (cnt_rs2 == CNT_W'(1));

  assign stall_raw = id_valid &&
                     ((id_use_rs1 && (cnt_rs1 != '0) && !rel_rs1) ||
                      (id_use_rs2 && (cnt_rs2 != '0) && !rel_rs2));
  assign stall_waw = id_valid && id_is_long && (id_rd != '0) && (cnt_rd == '1);
  assign stall     = stall_raw || stall_waw;

  assign issue        = id_valid && id_is_long && (id_rd != '0) && !stall && !flush;
  assign underflow_ev = wb_valid && (wb_rd != '0) && (cnt_wb == '0);

  for (genvar r = 0; r < TBL; r++) begin : g_reg
    if (r == 0 || r >= NUM_REGS) begin : g_zero
      assign pend_cnt[r] = '0;
    end else begin : g_cnt
      logic [CNT_W-1:0] cnt;
      logic             inc, dec;

      assign inc = issue && (id_rd == REG_W'(r));
      assign dec = wb_valid && !flush && (wb_rd == REG_W'(r)) && (cnt != '0);

      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          cnt <= '0;
        else if (flush)
          cnt <= '0;
        else if (inc && !dec)
          cnt <= cnt + 1'b1;
        else if (dec && !inc)
          cnt <= cnt - 1'b1;
      end

      assign pend_cnt[r] = cnt;
    end
    if (r < NUM_REGS) begin : g_busy
      assign busy_vec[r] = (pend_cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow_err <= 1'b0;
      stall_cycles  <= '0;
    end else begin
      if (underflow_ev)
        underflow_err <= 1'b1;
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid, id_use_rs1, id_use_rs2, id_is_long, wb_valid, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        stall, stall_raw, stall_waw, underflow_err;
  logic [31:0] busy_vec, stall_cycles;
  logic        nb_stall, nb_raw, nb_waw, nb_uf;
  logic [31:0] nb_busy, nb_sc;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_is_long(id_is_long),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .stall(stall), .stall_raw(stall_raw),
    .stall_waw(stall_waw), .busy_vec(busy_vec), .stall_cycles(stall_cycles),
    .underflow_err(underflow_err)
  );

  hazard_scoreboard #(.WB_BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_is_long(id_is_long),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .stall(nb_stall), .stall_raw(nb_raw),
    .stall_waw(nb_waw), .busy_vec(nb_busy), .stall_cycles(nb_sc), .underflow_err(nb_uf)
  );

  // Reference model: outstanding long writes per register as plain integers.
  int      pend [32];
  bit      m_uf;
  longint  m_sc;
  int      vectors = 0;
  int      miscompares = 0;
  logic    s_stall, s_raw, s_waw, s_nb;

  typedef struct {
    bit v; logic [4:0] rs1; bit u1; logic [4:0] rs2; bit u2; logic [4:0] rd; bit lg;
    bit wbv; logic [4:0] wbrd; bit fl;
    bit e_stall; bit e_raw; bit e_waw; logic [31:0] e_busy; bit e_uf;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit eff_busy(input int r);
    return pend[r] != 0 && !(wb_valid && int'(wb_rd) == r && pend[r] == 1);
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (pend[r] != 0);
    return b;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    m_uf = 0;
    m_sc = 0;
  endtask

  task automatic set_in(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit lg, input bit wbv, input int wbrd, input bit fl);
    id_valid = v; id_rs1 = 5'(rs1); id_use_rs1 = u1; id_rs2 = 5'(rs2); id_use_rs2 = u2;
    id_rd = 5'(rd); id_is_long = lg; wb_valid = wbv; wb_rd = 5'(wbrd); flush = fl;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic step();
    bit e_raw, e_waw, e_stall, iss, ret, uf_ev;
    #4;
    e_raw   = id_valid && ((id_use_rs1 && eff_busy(int'(id_rs1))) ||
                           (id_use_rs2 && eff_busy(int'(id_rs2))));
    e_waw   = id_valid && id_is_long && id_rd != 0 && pend[id_rd] == 3;
    e_stall = e_raw || e_waw;
    s_stall = stall; s_raw = stall_raw; s_waw = stall_waw; s_nb = nb_stall;
    check("stall", 64'(stall), 64'(e_stall));
    check("stall_raw", 64'(stall_raw), 64'(e_raw));
    check("stall_waw", 64'(stall_waw), 64'(e_waw));
    iss   = id_valid && id_is_long && id_rd != 0 && !e_stall && !flush;
    ret   = wb_valid && wb_rd != 0 && pend[wb_rd] != 0 && !flush;
    uf_ev = wb_valid && wb_rd != 0 && pend[wb_rd] == 0;
    if (flush) begin
      for (int r = 0; r < 32; r++) pend[r] = 0;
    end else begin
      if (iss) pend[id_rd] = pend[id_rd] + 1;
      if (ret) pend[wb_rd] = pend[wb_rd] - 1;
    end
    if (uf_ev) m_uf = 1;
    if (e_stall && m_sc < 64'hFFFF_FFFF) m_sc++;
    @(posedge clk);
    #1;
    check("busy_vec", 64'(busy_vec), 64'(model_busy()));
    check("stall_cycles", 64'(stall_cycles), 64'(m_sc));
    check("underflow_err", 64'(underflow_err), 64'(m_uf));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    idle();
    // Sequence from reset: issue/read r5, r0 handling, same-cycle issue+retire, underflow, flush.
    tbl[0] = '{1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 0, 0, 32'h0000_0020, 0};
    tbl[1] = '{1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 32'h0000_0020, 0};
    tbl[2] = '{1, 5, 1, 0, 0, 0, 0, 1, 5, 0,  0, 0, 0, 32'h0000_0000, 0};
    tbl[3] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0,  0, 0, 0, 32'h0000_0000, 0};
    tbl[4] = '{1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 32'h0000_0008, 0};
    tbl[5] = '{1, 0, 0, 0, 0, 3, 1, 1, 3, 0,  0, 0, 0, 32'h0000_0008, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 1, 9, 0,  0, 0, 0, 32'h0000_0008, 1};
    tbl[7] = '{1, 3, 0, 3, 1, 0, 0, 0, 0, 0,  1, 1, 0, 32'h0000_0008, 1};
    tbl[8] = '{1, 0, 0, 0, 0, 6, 1, 0, 0, 1,  0, 0, 0, 32'h0000_0000, 1};
    tbl[9] = '{1, 3, 0, 6, 1, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0000_0000, 1};

    do_reset();
    check("reset_busy", 64'(busy_vec), 64'h0);
    check("reset_stall_cycles", 64'(stall_cycles), 64'h0);
    check("reset_underflow", 64'(underflow_err), 64'h0);
    check("reset_stall", 64'(stall), 64'h0);

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].rd, tbl[i].lg,
             tbl[i].wbv, tbl[i].wbrd, tbl[i].fl);
      step();
      check($sformatf("tbl%0d_stall", i), 64'(s_stall), 64'(tbl[i].e_stall));
      check($sformatf("tbl%0d_raw", i), 64'(s_raw), 64'(tbl[i].e_raw));
      check($sformatf("tbl%0d_waw", i), 64'(s_waw), 64'(tbl[i].e_waw));
      check($sformatf("tbl%0d_busy", i), 64'(busy_vec), 64'(tbl[i].e_busy));
      check($sformatf("tbl%0d_uf", i), 64'(underflow_err), 64'(tbl[i].e_uf));
    end
    check("tbl_stall_cycles", 64'(stall_cycles), 64'd2);

    // Underflow survives flush, cleared only by reset.
    idle(); flush = 1'b1; step();
    check("uf_after_flush", 64'(underflow_err), 64'd1);
    do_reset();
    check("uf_after_reset", 64'(underflow_err), 64'd0);

    // Counter-full WAW on r7.
    for (int k = 0; k < 3; k++) begin
      set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); step();
    end
    set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); step();
    check("waw_full", 64'(s_waw), 64'd1);
    check("waw_full_raw", 64'(s_raw), 64'd0);
    set_in(1, 0, 0, 0, 0, 7, 1, 1, 7, 0); step();
    check("waw_full_with_wb", 64'(s_waw), 64'd1);
    set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); step();
    check("waw_fourth_issues", 64'(s_waw), 64'd0);
    set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); step();
    check("waw_full_again", 64'(s_waw), 64'd1);
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); step();
      check($sformatf("r7_busy_after_wb%0d", k), 64'(busy_vec[7]), 64'(k < 2));
    end

    // WB bypass versus one-cycle-late release.
    do_reset();
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); step();
    check("byp_stall_pre", 64'(s_stall), 64'd1);
    check("nobyp_stall_pre", 64'(s_nb), 64'd1);
    set_in(1, 5, 1, 0, 0, 0, 0, 1, 5, 0); step();
    check("byp_stall_wb", 64'(s_stall), 64'd0);
    check("nobyp_stall_wb", 64'(s_nb), 64'd1);
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); step();
    check("byp_stall_post", 64'(s_stall), 64'd0);
    check("nobyp_stall_post", 64'(s_nb), 64'd0);

    // Ten stall cycles, flush with simultaneous issue, then reset mid-stall.
    do_reset();
    set_in(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); step();
    set_in(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); step();
    for (int k = 0; k < 10; k++) begin
      set_in(1, 4, 1, 0, 0, 0, 0, 0, 0, 0); step();
    end
    check("stall_cycles_10", 64'(stall_cycles), 64'd10);
    set_in(1, 0, 0, 0, 0, 6, 1, 0, 0, 1); step();
    check("flush_busy", 64'(busy_vec), 64'h0);
    set_in(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); step();
    set_in(1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_stall", 64'(stall), 64'h0);
    check("async_rst_busy", 64'(busy_vec), 64'h0);
    check("async_rst_sc", 64'(stall_cycles), 64'h0);
    check("async_rst_uf", 64'(underflow_err), 64'h0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom_range(0, 9) < 8), $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 1), ($urandom_range(0, 9) < 4), $urandom_range(0, 7),
             ($urandom_range(0, 39) == 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
